io_input_stall: RTL and testbench

//  Produces stall_req_io for the pipeline control unit. A load from the switch-input

---
 rtl/io_input_stall.sv | 146 ++++++++++++++
 tb/tb_io_input_stall.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_stall.sv
// rtl/io_input_stall.sv - switch-input load stall with debounced enter button
// Optional build macro: IO_TIMEOUT_EN (bounds the WAIT state and reports io_timeout)
module io_input_stall #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DATA_W          = 16,
    parameter int TIMEOUT_CYCLES  = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_rd_req,
    input  logic              btn_enter,
    input  logic [DATA_W-1:0] sw_in,
    output logic              stall_req_io,
    output logic [31:0]       io_rd_data,
    output logic              io_rd_valid,
    output logic              enter_pulse,
    output logic              io_timeout
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            enter_pulse_q, enter_pulse_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            timeout_hit;

    // A new level is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row
    always_comb begin
        sync1_d       = btn_enter;
        sync2_d       = sync1_q;
        level_d       = level_q;
        db_cnt_d      = '0;
        enter_pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d       = ~level_q;
                enter_pulse_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    // Enter has priority over the terminal count
    assign timeout_hit = (state_q == ST_WAIT) && !enter_pulse_q && (wait_cnt_q == TO_LAST);

    always_comb begin
        wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
        timeout_d  = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign io_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign io_timeout  = 1'b0;
`endif

    always_comb begin
        rd_data_d = rd_data_q;
        if (state_q == ST_WAIT) begin
            if (enter_pulse_q) begin
                rd_data_d = 32'(sw_in);
            end else if (timeout_hit) begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            level_q       <= 1'b0;
            enter_pulse_q <= 1'b0;
            db_cnt_q      <= '0;
            rd_data_q     <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            enter_pulse_q <= enter_pulse_d;
            db_cnt_q      <= db_cnt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pulse already present on the IDLE->WAIT cycle is not seen, since only WAIT looks at it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (io_rd_req) state_d = ST_WAIT;
            ST_WAIT: if (enter_pulse_q || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req_io = 1'b0;
        io_rd_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: stall_req_io = io_rd_req;
            ST_WAIT: stall_req_io = 1'b1;
            ST_DONE: io_rd_valid  = 1'b1;
            default: stall_req_io = 1'b0;
        endcase
        if (rst) begin
            stall_req_io = 1'b0;
        end
    end

    assign io_rd_data  = rd_data_q;
    assign enter_pulse = enter_pulse_q;

endmodule

// File: tb/tb_io_input_stall.sv
// tb/tb_io_input_stall.sv - self-checking bench for io_input_stall against a behavioural model
module tb_io_input_stall;
    localparam int DEB = 4;
    localparam int TO  = 50;
    localparam int DW  = 16;
`ifdef IO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          io_rd_req = 1'b0;
    logic          btn_enter = 1'b0;
    logic [DW-1:0] sw_in = '0;
    logic          stall_req_io, io_rd_valid, enter_pulse, io_timeout;
    logic [31:0]   io_rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle 1=waiting 2=done; button seen two edges late
    int          m_phase = 0;
    logic [31:0] m_data = '0;
    bit          m_pulse = 1'b0, m_lvl = 1'b0, m_to = 1'b0, m_h0 = 1'b0, m_h1 = 1'b0;
    int          m_run = 0, m_waited = 0;

    always #5 clk = ~clk;

    io_input_stall #(.DEBOUNCE_CYCLES(DEB), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .io_rd_req(io_rd_req), .btn_enter(btn_enter), .sw_in(sw_in),
        .stall_req_io(stall_req_io), .io_rd_data(io_rd_data), .io_rd_valid(io_rd_valid),
        .enter_pulse(enter_pulse), .io_timeout(io_timeout)
    );

    always @(posedge clk) begin : model
        bit syn;
        if (rst) begin
            m_phase = 0; m_data = '0; m_pulse = 0; m_lvl = 0; m_to = 0;
            m_h0 = 0; m_h1 = 0; m_run = 0; m_waited = 0;
        end else begin
            m_to = 1'b0;
            if (m_phase == 0) begin
                if (io_rd_req) begin m_phase = 1; m_waited = 0; end
            end else if (m_phase == 1) begin
                if (m_pulse) begin
                    m_data = {16'h0, sw_in}; m_phase = 2;
                end else if (TO_EN && m_waited == TO - 1) begin
                    m_data = '0; m_phase = 2; m_to = 1'b1;
                end else begin
                    m_waited++;
                end
            end else begin
                m_phase = 0;
            end
            syn = m_h1; m_h1 = m_h0; m_h0 = btn_enter;
            m_pulse = 1'b0;
            if (syn != m_lvl) begin
                m_run++;
                if (m_run == DEB) begin m_lvl = ~m_lvl; m_run = 0; m_pulse = m_lvl; end
            end else begin
                m_run = 0;
            end
        end
    end

    function automatic bit exp_stall();
        return !rst && (m_phase == 1 || (m_phase == 0 && io_rd_req));
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; io_rd_req = 1'b1; btn_enter = 1'b0; sw_in = 16'hFFFF;
        repeat (3) begin
            tick();
            checks++;
            if (stall_req_io !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req_io); end
        end
        checks += 4;
        if (io_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", io_rd_valid); end
        if (io_rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", io_rd_data); end
        if (enter_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", enter_pulse); end
        if (io_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", io_timeout); end
        rst = 1'b0; io_rd_req = 1'b0;
        repeat (10) begin
            tick();
            checks++;
            if ({stall_req_io, io_rd_valid, enter_pulse, io_timeout, io_rd_data} !== 36'h0) begin
                errors++;
                $display("FAIL idle_outputs: got stall=%b valid=%b pulse=%b to=%b data=%h want all 0", stall_req_io, io_rd_valid, enter_pulse, io_timeout, io_rd_data);
            end
        end
    endtask

    task automatic test_basic_read();
        int  pulses = 0;
        bit  done = 1'b0;
        int  i = 0;
        sw_in = 16'hA5A5; io_rd_req = 1'b1;
        #1;
        checks++;
        if (stall_req_io !== 1'b1) begin errors++; $display("FAIL basic_req_stall: got %b want 1", stall_req_io); end
        btn_enter = 1'b1;
        while (i < 30 && !done) begin
            tick(); i++;
            if (enter_pulse === 1'b1) pulses++;
            checks += 3;
            if (stall_req_io !== exp_stall()) begin errors++; $display("FAIL basic_stall: got %b want %b", stall_req_io, exp_stall()); end
            if (io_rd_valid !== (m_phase == 2)) begin errors++; $display("FAIL basic_valid: got %b want %b", io_rd_valid, m_phase == 2); end
            if (enter_pulse !== m_pulse) begin errors++; $display("FAIL basic_pulse: got %b want %b", enter_pulse, m_pulse); end
            if (io_rd_valid === 1'b1) begin
                done = 1'b1;
                checks += 2;
                if (io_rd_data !== 32'h0000A5A5) begin errors++; $display("FAIL basic_data: got %h want 0000a5a5", io_rd_data); end
                if (stall_req_io !== 1'b0) begin errors++; $display("FAIL basic_done_stall: got %b want 0", stall_req_io); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL basic_no_valid: got none within 30 cycles want io_rd_valid"); end
        tick(); i++;
        io_rd_req = 1'b0; sw_in = 16'h1234;
        #1;
        checks++;
        if (stall_req_io !== 1'b0) begin errors++; $display("FAIL basic_after_done_stall: got %b want 0", stall_req_io); end
        while (i < 24) begin
            if (i >= 10) btn_enter = 1'b0;
            tick(); i++;
            if (enter_pulse === 1'b1) pulses++;
            checks += 2;
            if (io_rd_data !== 32'h0000A5A5) begin errors++; $display("FAIL basic_hold_data: got %h want 0000a5a5", io_rd_data); end
            if (io_rd_valid !== 1'b0) begin errors++; $display("FAIL basic_extra_valid: got %b want 0", io_rd_valid); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL basic_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        bit done = 1'b0;
        io_rd_req = 1'b1; sw_in = 16'h3C3C;
        for (int i = 0; i < 30; i++) begin
            btn_enter = (i < 12) ? ((i / 3) % 2 == 0) : 1'b1;
            if (done) io_rd_req = 1'b0;
            tick();
            if (enter_pulse === 1'b1) pulses++;
            checks += 2;
            if (enter_pulse !== m_pulse) begin errors++; $display("FAIL bounce_pulse: got %b want %b cycle %0d", enter_pulse, m_pulse, i); end
            if (stall_req_io !== exp_stall()) begin errors++; $display("FAIL bounce_stall: got %b want %b cycle %0d", stall_req_io, exp_stall(), i); end
            if (i < 14) begin
                checks++;
                if (enter_pulse !== 1'b0) begin errors++; $display("FAIL bounce_early_pulse: got %b want 0 cycle %0d", enter_pulse, i); end
            end
            if (io_rd_valid === 1'b1) begin
                done = 1'b1;
                checks++;
                if (io_rd_data !== 32'h00003C3C) begin errors++; $display("FAIL bounce_data: got %h want 00003c3c", io_rd_data); end
            end
        end
        checks += 2;
        if (pulses != 1) begin errors++; $display("FAIL bounce_pulse_count: got %0d want 1", pulses); end
        if (!done) begin errors++; $display("FAIL bounce_no_valid: got none want io_rd_valid"); end
        io_rd_req = 1'b0; btn_enter = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_held_press();
        bit done = 1'b0;
        int n = 0;
        btn_enter = 1'b1; io_rd_req = 1'b0; sw_in = 16'h00C3;
        repeat (10) tick();
        io_rd_req = 1'b1;
        repeat (20) begin
            tick();
            checks += 2;
            if (stall_req_io !== 1'b1) begin errors++; $display("FAIL held_stall: got %b want 1", stall_req_io); end
            if (io_rd_valid !== 1'b0) begin errors++; $display("FAIL held_valid: got %b want 0", io_rd_valid); end
        end
        btn_enter = 1'b0;
        repeat (8) begin
            tick();
            checks++;
            if (stall_req_io !== 1'b1) begin errors++; $display("FAIL held_release_stall: got %b want 1", stall_req_io); end
        end
        btn_enter = 1'b1;
        while (n < 20 && !done) begin
            tick(); n++;
            checks++;
            if (enter_pulse !== m_pulse) begin errors++; $display("FAIL held_pulse: got %b want %b", enter_pulse, m_pulse); end
            if (io_rd_valid === 1'b1) begin
                done = 1'b1;
                checks++;
                if (io_rd_data !== 32'h000000C3) begin errors++; $display("FAIL held_data: got %h want 000000c3", io_rd_data); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL held_no_valid: got none want io_rd_valid after new press"); end
        io_rd_req = 1'b0; btn_enter = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_in_wait();
        io_rd_req = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (stall_req_io !== 1'b0) begin errors++; $display("FAIL rstwait_stall: got %b want 0", stall_req_io); end
        tick();
        rst = 1'b0; io_rd_req = 1'b0;
        repeat (10) begin
            tick();
            checks += 2;
            if (io_rd_valid !== 1'b0) begin errors++; $display("FAIL rstwait_valid: got %b want 0", io_rd_valid); end
            if (stall_req_io !== 1'b0) begin errors++; $display("FAIL rstwait_idle_stall: got %b want 0", stall_req_io); end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int prev_phase = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin btn_enter = $urandom_range(1, 0); hold = $urandom_range(8, 1); end
            hold--;
            sw_in = DW'($urandom);
            rst = ($urandom_range(79, 0) == 0);
            if (m_phase == 0) io_rd_req = (prev_phase == 2) ? 1'b0 : ($urandom_range(3, 0) == 0);
            else io_rd_req = 1'b1;
            prev_phase = m_phase;
            tick();
            checks += 5;
            if (stall_req_io !== exp_stall()) begin errors++; $display("FAIL rand_stall: got %b want %b cycle %0d", stall_req_io, exp_stall(), i); end
            if (io_rd_valid !== (m_phase == 2)) begin errors++; $display("FAIL rand_valid: got %b want %b cycle %0d", io_rd_valid, m_phase == 2, i); end
            if (io_rd_data !== m_data) begin errors++; $display("FAIL rand_data: got %h want %h cycle %0d", io_rd_data, m_data, i); end
            if (enter_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse: got %b want %b cycle %0d", enter_pulse, m_pulse, i); end
            if (io_timeout !== m_to) begin errors++; $display("FAIL rand_timeout: got %b want %b cycle %0d", io_timeout, m_to, i); end
        end
        btn_enter = 1'b0; io_rd_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_timeout();
        bit done = 1'b0;
        int n = 0;
        sw_in = 16'h0F0F; io_rd_req = 1'b1;
`ifdef IO_TIMEOUT_EN
        while (n < 80 && !done) begin
            tick(); n++;
            checks += 2;
            if (stall_req_io !== exp_stall()) begin errors++; $display("FAIL to_stall: got %b want %b", stall_req_io, exp_stall()); end
            if (io_timeout !== m_to) begin errors++; $display("FAIL to_flag: got %b want %b", io_timeout, m_to); end
            if (io_rd_valid === 1'b1) begin
                done = 1'b1;
                checks += 4;
                if (n != TO + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
                if (io_timeout !== 1'b1) begin errors++; $display("FAIL to_done_flag: got %b want 1", io_timeout); end
                if (io_rd_data !== 32'h0) begin errors++; $display("FAIL to_data: got %h want 0", io_rd_data); end
                if (stall_req_io !== 1'b0) begin errors++; $display("FAIL to_release: got %b want 0", stall_req_io); end
                io_rd_req = 1'b0;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL to_no_valid: got none within 80 cycles want timeout completion"); end
`else
        repeat (70) begin
            tick();
            checks += 3;
            if (stall_req_io !== 1'b1) begin errors++; $display("FAIL noto_stall: got %b want 1", stall_req_io); end
            if (io_rd_valid !== 1'b0) begin errors++; $display("FAIL noto_valid: got %b want 0", io_rd_valid); end
            if (io_timeout !== 1'b0) begin errors++; $display("FAIL noto_flag: got %b want 0", io_timeout); end
        end
        btn_enter = 1'b1;
        while (n < 20 && !done) begin
            tick(); n++;
            if (io_rd_valid === 1'b1) begin
                done = 1'b1;
                checks += 2;
                if (io_rd_data !== 32'h00000F0F) begin errors++; $display("FAIL noto_data: got %h want 00000f0f", io_rd_data); end
                if (io_timeout !== 1'b0) begin errors++; $display("FAIL noto_done_flag: got %b want 0", io_timeout); end
                io_rd_req = 1'b0;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL noto_no_valid: got none want io_rd_valid after press"); end
`endif
        io_rd_req = 1'b0; btn_enter = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_bounce();
        test_held_press();
        test_reset_in_wait();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
